// File: rtl/l1_cache_pkg.sv
// Shared types and geometry for the 2-way write-back L1 cache.
package l1_cache_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned INDEX_W  = 3;
    localparam int unsigned OFFSET_W = 5;
    localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned LINE_W   = 8 << OFFSET_W;
    localparam int unsigned NUM_WAYS = 2;

    // Controller states: serve hits, write back a dirty victim, fill a line.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_e;

endpackage

// File: rtl/l1_cache_control.sv
// Miss-handling controller: hit response, victim writeback and line fill sequencing.
module l1_cache_control
    import l1_cache_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    input  logic i_tag_hit,
    input  logic i_victim_dirty,
    input  logic i_pmem_resp,
    output logic o_resp,
    output logic o_hit,
    output logic o_latch,
    output logic o_fill,
    output logic o_pmem_read,
    output logic o_pmem_write
);

    state_e r_state;
    state_e w_state_nxt;

    // State register; reset abandons any transfer in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control strobes.
    always_comb begin
        w_state_nxt  = r_state;
        o_resp       = 1'b0;
        o_hit        = 1'b0;
        o_latch      = 1'b0;
        o_fill       = 1'b0;
        o_pmem_read  = 1'b0;
        o_pmem_write = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req) begin
                    if (i_tag_hit) begin
                        o_resp = 1'b1;
                        o_hit  = 1'b1;
                    end else begin
                        o_latch     = 1'b1;
                        w_state_nxt = i_victim_dirty ? WRITEBACK : FILL;
                    end
                end
            end
            WRITEBACK: begin
                o_pmem_write = 1'b1;
                if (i_pmem_resp) begin
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                o_pmem_read = 1'b1;
                if (i_pmem_resp) begin
                    o_fill      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/l1_cache.sv
// 2-way set-associative write-back/write-allocate L1 cache datapath.
module l1_cache
    import l1_cache_pkg::*;
#(
    parameter int unsigned s_index  = INDEX_W,
    parameter int unsigned s_offset = OFFSET_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mem_read,
    input  logic                         mem_write,
    input  logic [3:0]                   mem_byte_enable,
    input  logic [ADDR_W-1:0]            mem_address,
    input  logic [WORD_W-1:0]            mem_wdata,
    output logic [WORD_W-1:0]            mem_rdata,
    output logic                         mem_resp,
    output logic                         hit,
    output logic                         pmem_read,
    output logic                         pmem_write,
    output logic [ADDR_W-1:0]            pmem_address,
    output logic [(8 << s_offset)-1:0]   pmem_wdata,
    input  logic [(8 << s_offset)-1:0]   pmem_rdata,
    input  logic                         pmem_resp
);

    localparam int unsigned SETS       = 1 << s_index;
    localparam int unsigned LINE_BITS  = 8 << s_offset;
    localparam int unsigned TAG_BITS   = ADDR_W - s_index - s_offset;
    localparam int unsigned WORD_SEL_W = s_offset - 2;

    logic [LINE_BITS-1:0]  r_data  [NUM_WAYS][SETS];
    logic [TAG_BITS-1:0]   r_tag   [NUM_WAYS][SETS];
    logic [SETS-1:0]       r_valid [NUM_WAYS];
    logic [SETS-1:0]       r_dirty [NUM_WAYS];
    logic [SETS-1:0]       r_lru;

    logic [TAG_BITS-1:0]   r_miss_tag;
    logic [s_index-1:0]    r_miss_idx;
    logic                  r_victim;

    logic [TAG_BITS-1:0]   w_tag;
    logic [s_index-1:0]    w_idx;
    logic [WORD_SEL_W-1:0] w_word;
    logic                  w_hit0;
    logic                  w_hit1;
    logic                  w_tag_hit;
    logic                  w_hit_way;
    logic                  w_victim;
    logic                  w_victim_dirty;
    logic                  w_req;
    logic                  w_resp;
    logic                  w_latch;
    logic                  w_fill;
    logic                  w_unused;

    // Address decode and tag compare on the live request.
    assign w_tag     = mem_address[ADDR_W-1 -: TAG_BITS];
    assign w_idx     = mem_address[s_offset +: s_index];
    assign w_word    = mem_address[s_offset-1:2];
    assign w_unused  = &{1'b0, mem_address[1:0]};
    assign w_req     = mem_read | mem_write;
    assign w_hit0    = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
    assign w_hit1    = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
    assign w_tag_hit = w_hit0 | w_hit1;
    assign w_hit_way = w_hit1;

    // Victim: first invalid way, otherwise the LRU way.
    assign w_victim       = !r_valid[0][w_idx] ? 1'b0 :
                            (!r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx]);
    assign w_victim_dirty = r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx];

    l1_cache_control u_control (
        .clk            (clk),
        .reset          (reset),
        .i_req          (w_req),
        .i_tag_hit      (w_tag_hit),
        .i_victim_dirty (w_victim_dirty),
        .i_pmem_resp    (pmem_resp),
        .o_resp         (w_resp),
        .o_hit          (hit),
        .o_latch        (w_latch),
        .o_fill         (w_fill),
        .o_pmem_read    (pmem_read),
        .o_pmem_write   (pmem_write)
    );

    assign mem_resp  = w_resp;
    assign mem_rdata = r_data[w_hit_way][w_idx][{w_word, 5'd0} +: WORD_W];

    // Writeback targets the victim's own line; fill targets the latched miss line.
    assign pmem_address = pmem_write ?
                          {r_tag[r_victim][r_miss_idx], r_miss_idx, {s_offset{1'b0}}} :
                          {r_miss_tag, r_miss_idx, {s_offset{1'b0}}};
    assign pmem_wdata   = r_data[r_victim][r_miss_idx];

    // Status bits and miss bookkeeping; reset wipes validity, dirtiness and LRU.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                r_valid[w] <= '0;
                r_dirty[w] <= '0;
            end
            r_lru      <= '0;
            r_miss_tag <= '0;
            r_miss_idx <= '0;
            r_victim   <= 1'b0;
        end else begin
            if (w_latch) begin
                r_miss_tag <= w_tag;
                r_miss_idx <= w_idx;
                r_victim   <= w_victim;
            end
            if (w_resp) begin
                r_lru[w_idx] <= ~w_hit_way;
                if (mem_write) begin
                    r_dirty[w_hit_way][w_idx] <= 1'b1;
                end
            end
            if (w_fill) begin
                r_valid[r_victim][r_miss_idx] <= 1'b1;
                r_dirty[r_victim][r_miss_idx] <= 1'b0;
            end
        end
    end

    // Data and tag arrays carry no reset; validity gates their use.
    always_ff @(posedge clk) begin
        if (w_resp && mem_write) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_byte_enable[b]) begin
                    r_data[w_hit_way][w_idx][{w_word, 2'(b), 3'd0} +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
        if (w_fill) begin
            r_data[r_victim][r_miss_idx] <= pmem_rdata;
            r_tag[r_victim][r_miss_idx]  <= r_miss_tag;
        end
    end

endmodule
